// File: rtl/axis_inst_buffer_128_if.sv
// AXI4-Stream bundle used on both sides of the instruction buffer.
//   tdata  : stream word
//   tkeep  : byte strobes
//   tlast  : batch delimiter
//   tvalid : source has a word
//   tready : sink can take it
// master modport drives the stream; slave modport receives it.
interface axis_inst_buffer_128_if #(
  parameter int unsigned C_DATA_WIDTH = 128
);
  logic [C_DATA_WIDTH-1:0]   tdata;
  logic [C_DATA_WIDTH/8-1:0] tkeep;
  logic                      tlast;
  logic                      tvalid;
  logic                      tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_inst_buffer_128.sv
// Instruction buffer: circular FIFO between the write-to-stream bridge and the
// instruction consumer, with a registered first-word-fall-through output.
//   S_AXIS_ACLK    : sole clock, rising edge
//   S_AXIS_ARESETN : asynchronous active-low reset
//   S_AXIS         : incoming instruction stream (slave); partial-strobe words dropped
//   M_AXIS         : outgoing instruction stream (master); tkeep is always all-ones
//   FLUSH          : synchronous single-cycle clear of the stored contents
//   OCCUPANCY      : stored words including the output register
//   ALMOST_FULL    : free entries <= C_AFULL_MARGIN
//   DROP_COUNT     : saturating count of discarded words
//   BATCH_OVF      : sticky, a forced batch release happened
// Optional feature: define INST_BUF_BATCH_EN to hold output until a full
// TLAST-delimited batch is stored.
module axis_inst_buffer_128 #(
  parameter int unsigned C_DATA_WIDTH   = 128,
  parameter int unsigned C_DEPTH_LOG2   = 9,
  parameter int unsigned C_AFULL_MARGIN = 8
) (
  input  logic                          S_AXIS_ACLK,
  input  logic                          S_AXIS_ARESETN,
  axis_inst_buffer_128_if.slave         S_AXIS,
  axis_inst_buffer_128_if.master        M_AXIS,
  input  logic                          FLUSH,
  output logic [C_DEPTH_LOG2:0]         OCCUPANCY,
  output logic                          ALMOST_FULL,
  output logic [15:0]                   DROP_COUNT,
  output logic                          BATCH_OVF
);
  localparam int unsigned AW = C_DEPTH_LOG2;
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_LVL   = FULL_LVL - (AW+1)'(C_AFULL_MARGIN);

  logic [C_DATA_WIDTH:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             ram_cnt, ram_cnt_nxt;
  logic [AW:0]             occ, occ_nxt;
  logic                    afull;
  logic                    out_valid, out_last;
  logic [C_DATA_WIDTH-1:0] out_data;
  logic [15:0]             drop_cnt;
  logic                    accept, store, drop, pop, eligible, refill;

  assign S_AXIS.tready = (occ < FULL_LVL) && !FLUSH;
  assign accept = S_AXIS.tvalid && S_AXIS.tready;
  assign store  = accept && (&S_AXIS.tkeep);
  assign drop   = accept && !(&S_AXIS.tkeep);
  assign pop    = out_valid && M_AXIS.tready;
  assign refill = (!out_valid || pop) && (ram_cnt != '0) && eligible;

  assign M_AXIS.tdata  = out_data;
  assign M_AXIS.tlast  = out_last;
  assign M_AXIS.tvalid = out_valid;
  assign M_AXIS.tkeep  = '1;
  assign OCCUPANCY     = occ;
  assign ALMOST_FULL   = afull;
  assign DROP_COUNT    = drop_cnt;

`ifdef INST_BUF_BATCH_EN
  logic [AW:0] batch_cnt;
  logic        force_rel, ovf, pop_last;

  assign pop_last = pop && out_last;
  // A batch end leaving the output register this cycle no longer counts, so
  // eligibility looks at the counter as it will be after the pop.
  assign eligible = (force_rel && !pop_last) ||
                    (batch_cnt > {{AW{1'b0}}, pop_last});
  assign BATCH_OVF = ovf;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      batch_cnt <= '0;
      force_rel <= 1'b0;
      ovf       <= 1'b0;
    end else if (FLUSH) begin
      batch_cnt <= '0;
      force_rel <= 1'b0;
    end else begin
      case ({store && S_AXIS.tlast, pop_last})
        2'b10:   batch_cnt <= batch_cnt + 1'b1;
        2'b01:   batch_cnt <= batch_cnt - 1'b1;
        default: ;
      endcase
      // Full with no complete batch would deadlock; release until a TLAST pops.
      if (occ == FULL_LVL && batch_cnt == '0) begin
        force_rel <= 1'b1;
        ovf       <= 1'b1;
      end else if (pop_last) begin
        force_rel <= 1'b0;
      end
    end
  end
`else
  assign eligible  = 1'b1;
  assign BATCH_OVF = 1'b0;
`endif

  always_comb begin
    occ_nxt = occ;
    case ({store, pop})
      2'b10:   occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: ;
    endcase
    ram_cnt_nxt = ram_cnt;
    case ({store, refill})
      2'b10:   ram_cnt_nxt = ram_cnt + 1'b1;
      2'b01:   ram_cnt_nxt = ram_cnt - 1'b1;
      default: ;
    endcase
  end

  // Storage array carries no reset; the pointers define its contents.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (store) mem[wr_ptr] <= {S_AXIS.tlast, S_AXIS.tdata};
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      occ       <= '0;
      afull     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (FLUSH) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      occ       <= '0;
      afull     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (store)  wr_ptr <= wr_ptr + 1'b1;
      if (refill) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt <= ram_cnt_nxt;
      occ     <= occ_nxt;
      afull   <= (occ_nxt >= AF_LVL);
      if (refill) begin
        out_valid             <= 1'b1;
        {out_last, out_data}  <= mem[rd_ptr];
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN)           drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end
endmodule

// File: tb/tb_axis_inst_buffer_128.sv
// Bench for axis_inst_buffer_128: a table of single-word vectors plus
// hand-written sequences; a negedge scoreboard checks every output word.
module tb_axis_inst_buffer_128;
`ifdef INST_BUF_BATCH_EN
  localparam logic BATCH = 1'b1;
`else
  localparam logic BATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [9:0]  occ;
  logic        af;
  logic [15:0] drop;
  logic        ovf;

  always #5 clk = ~clk;

  axis_inst_buffer_128_if #(.C_DATA_WIDTH(128)) s_if ();
  axis_inst_buffer_128_if #(.C_DATA_WIDTH(128)) m_if ();

  axis_inst_buffer_128 #(
    .C_DATA_WIDTH(128), .C_DEPTH_LOG2(9), .C_AFULL_MARGIN(8)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
    .S_AXIS(s_if), .M_AXIS(m_if),
    .FLUSH(flush), .OCCUPANCY(occ), .ALMOST_FULL(af),
    .DROP_COUNT(drop), .BATCH_OVF(ovf)
  );

  typedef logic [128:0] word_t;
  word_t sb[$];
  word_t exp_w;
  int errors = 0;
  int checks = 0;
  int popped = 0;

  task automatic check(input string name, input logic [128:0] got, input logic [128:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: pop/compare first, then record the accepted word.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          exp_w = sb.pop_front();
          check("sb_data", {m_if.tlast, m_if.tdata}, exp_w);
          popped++;
        end
      end
      if (s_if.tvalid && s_if.tready && (&s_if.tkeep))
        sb.push_back({s_if.tlast, s_if.tdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
    logic ok;
    ok = 1'b0;
    s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tvalid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (s_if.tready) begin ok = 1'b1; tick(); break; end
      tick();
    end
    check("send_timeout", ok, 1'b1);
  endtask

  task automatic drain(input int bound);
    logic ok;
    ok = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (occ == 0) begin ok = 1'b1; break; end
      tick();
    end
    check("drain_timeout", ok, 1'b1);
  endtask

  function automatic logic [127:0] mkdata(input int unsigned seq);
    return {$urandom, $urandom, $urandom, seq};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_tready"}, s_if.tready, 1'b1);
    check({tag, "_occ"}, occ, 10'd0);
    check({tag, "_af"}, af, 1'b0);
    check({tag, "_drop"}, drop, 16'd0);
    check({tag, "_ovf"}, ovf, 1'b0);
    check({tag, "_mvalid"}, m_if.tvalid, 1'b0);
    check({tag, "_mdata"}, m_if.tdata, 128'd0);
    check({tag, "_mlast"}, m_if.tlast, 1'b0);
  endtask

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic         exp_valid;
    logic         exp_last;
    logic [15:0]  exp_drop;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [127:0] w0, w1;
    logic af503, af504, hs;
    int unsigned seq;
    int p0;
    logic [15:0] d0;

    vt[0] = '{128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 16'hFFFF, BATCH,  1'b1, BATCH, 16'd0};
    vt[1] = '{128'hdead_beef_dead_beef_dead_beef_dead_beef, 16'h00FF, 1'b1,   1'b0, 1'b0,  16'd1};
    vt[2] = '{128'hfeed_face_cafe_f00d_1234_5678_9abc_def0, 16'hFFFF, 1'b1,   1'b1, 1'b1,  16'd1};
    vt[3] = '{128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0000, 1'b0,   1'b0, 1'b0,  16'd2};
    vt[4] = '{128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000, 16'hFFFE, 1'b0,   1'b0, 1'b0,  16'd3};
    vt[5] = '{128'h5a5a_a5a5_5a5a_a5a5_0f0f_f0f0_0f0f_f0f0, 16'hFFFF, BATCH,  1'b1, BATCH, 16'd3};

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '1; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;

    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_reset_vals("reset");

    // Single-word vectors into an empty buffer.
    for (int i = 0; i < 6; i++) begin
      send(vt[i].data, vt[i].keep, vt[i].last);
      s_if.tvalid = 1'b0;
      tick();
      check($sformatf("vec%0d_valid", i), m_if.tvalid, vt[i].exp_valid);
      if (vt[i].exp_valid) check($sformatf("vec%0d_last", i), m_if.tlast, vt[i].exp_last);
      check($sformatf("vec%0d_occ", i), occ, {9'd0, vt[i].exp_valid});
      check($sformatf("vec%0d_drop", i), drop, vt[i].exp_drop);
      if (vt[i].exp_valid) begin
        m_if.tready = 1'b1; tick(); m_if.tready = 1'b0;
        check($sformatf("vec%0d_occ_after_pop", i), occ, 10'd0);
      end
    end

    // Three-word burst, consumer always ready.
    m_if.tready = 1'b1;
    w0 = mkdata(32'h100); w1 = mkdata(32'h101);
    send(w0, 16'hFFFF, 1'b0);
`ifndef INST_BUF_BATCH_EN
    check("burst_lat_valid0", m_if.tvalid, 1'b0);
`endif
    send(w1, 16'hFFFF, 1'b0);
`ifndef INST_BUF_BATCH_EN
    check("burst_lat_valid1", m_if.tvalid, 1'b1);
    check("burst_lat_data", m_if.tdata, w0);
`endif
    send(mkdata(32'h102), 16'hFFFF, 1'b1);
    s_if.tvalid = 1'b0;
    drain(50);
    check("burst_occ_end", occ, 10'd0);
    check("burst_sb_empty", sb.size(), 0);

    // Partial-strobe word between two legal words.
    d0 = drop; p0 = popped;
    send(mkdata(32'h200), 16'hFFFF, BATCH);
    send(mkdata(32'h201), 16'h00FF, 1'b0);
    send(mkdata(32'h202), 16'hFFFF, 1'b1);
    s_if.tvalid = 1'b0;
    drain(50);
    tick();
    check("drop_count_inc", drop, d0 + 16'd1);
    check("drop_popped", popped - p0, 2);

    // Fill to full with the consumer stalled.
    m_if.tready = 1'b0;
    af503 = 1'b1; af504 = 1'b0; seq = 0; p0 = popped;
    for (int i = 0; i < 700 && occ != 10'd512; i++) begin
      s_if.tdata = mkdata(seq); s_if.tkeep = '1;
      s_if.tlast = BATCH | ($urandom_range(0, 7) == 0);
      s_if.tvalid = 1'b1;
      hs = s_if.tready;
      tick();
      if (hs) seq++;
      if (occ == 10'd503) af503 = af;
      if (occ == 10'd504) af504 = af;
    end
    check("fill_occ", occ, 10'd512);
    check("fill_tready_low", s_if.tready, 1'b0);
    check("fill_af_at_503", af503, 1'b0);
    check("fill_af_at_504", af504, 1'b1);
    repeat (2) tick();
    check("full_no_accept", occ, 10'd512);

    // Pop and push together across pointer wrap.
    m_if.tready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      s_if.tdata = mkdata(seq); s_if.tkeep = '1;
      s_if.tlast = BATCH | ($urandom_range(0, 7) == 0);
      hs = s_if.tready;
      tick();
      if (hs) seq++;
    end
    s_if.tvalid = 1'b0;
    drain(1200);
    check("wrap_sb_empty", sb.size(), 0);
    check("wrap_count", popped - p0, int'(seq));

    // FLUSH with 10 words stored.
    m_if.tready = 1'b0;
    d0 = drop;
    for (int i = 0; i < 10; i++) send(mkdata(32'h300 + i), 16'hFFFF, BATCH);
    check("flush_pre_occ", occ, 10'd10);
    check("flush_pre_valid", m_if.tvalid, 1'b1);
    s_if.tdata = mkdata(32'h3FF); s_if.tlast = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_tready", s_if.tready, 1'b0);
    tick();
    flush = 1'b0; s_if.tvalid = 1'b0;
    sb.delete();
    check("flush_valid", m_if.tvalid, 1'b0);
    check("flush_occ", occ, 10'd0);
    check("flush_drop_kept", drop, d0);
    repeat (3) tick();
    check("flush_word_not_taken", occ, 10'd0);
    check("flush_valid_after", m_if.tvalid, 1'b0);

`ifdef INST_BUF_BATCH_EN
    // Batch hold, then release on TLAST.
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) send(mkdata(32'h400 + i), 16'hFFFF, 1'b0);
    s_if.tvalid = 1'b0;
    repeat (4) tick();
    check("batch_hold_valid", m_if.tvalid, 1'b0);
    check("batch_hold_occ", occ, 10'd4);
    p0 = popped;
    send(mkdata(32'h404), 16'hFFFF, 1'b1);
    s_if.tvalid = 1'b0;
    drain(50);
    check("batch_release_count", popped - p0, 5);

    // No TLAST at all: forced release.
    p0 = popped;
    for (int i = 0; i < 512; i++) send(mkdata(32'h500 + i), 16'hFFFF, 1'b0);
    s_if.tvalid = 1'b0;
    for (int i = 0; i < 20 && !ovf; i++) tick();
    check("batch_ovf", ovf, 1'b1);
    drain(2000);
    check("batch_forced_count", popped - p0, 512);
    check("batch_forced_sb_empty", sb.size(), 0);
`else
    check("ovf_tied_low", ovf, 1'b0);
`endif

    // Asynchronous reset mid-burst.
    m_if.tready = 1'b0;
    for (int i = 0; i < 20; i++) send(mkdata(32'h600 + i), 16'hFFFF, 1'b1);
    check("areset_pre_occ", occ, 10'd20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("areset");
    s_if.tvalid = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("areset_post_valid", m_if.tvalid, 1'b0);
    check("areset_post_occ", occ, 10'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
